// File: rtl/mod_mult_serial_pkg.sv
// Shared types and helpers for the serial chunked multiplier: FSM state,
// chunk-count / counter-width functions and the highest non-zero chunk finder.
package mod_mult_serial_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Widest operand the chunk finder accepts; callers zero-extend into it.
  localparam int MAX_W = 512;

  function automatic int nb_chunk(input int mod_w, input int chunk_w);
    return mod_w / chunk_w;
  endfunction

  function automatic int cnt_w(input int mod_w, input int chunk_w);
    int n;
    n = nb_chunk(mod_w, chunk_w);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Index of the highest chunk_w-wide slice of b holding a set bit; 0 if b==0.
  function automatic int highest_nz_chunk(input logic [MAX_W-1:0] b,
                                          input int mod_w,
                                          input int chunk_w);
    int res;
    res = 0;
    for (int j = 0; j < MAX_W; j++) begin
      if ((j < mod_w) && b[j]) res = j / chunk_w;
    end
    return res;
  endfunction

endpackage

// File: rtl/mod_mult_serial_prod_if.sv
// Operand/result bundle between the upstream producer and mod_mult_serial_prod.
// Side-data fields are kept one bit wide when SIDE_W is 0 so the bus stays legal.
interface mod_mult_serial_prod_if #(
  parameter int MOD_W  = 64,
  parameter int SIDE_W = 0
);
  localparam int SW = (SIDE_W > 0) ? SIDE_W : 1;

  logic [MOD_W-1:0]   in_a;
  logic [MOD_W-1:0]   in_b;
  logic [SW-1:0]      in_side;
  logic               in_vld;
  logic               in_rdy;
  logic [2*MOD_W-1:0] out_z;
  logic [SW-1:0]      out_side;
  logic               out_avail;

  modport master (
    output in_a, in_b, in_side, in_vld,
    input  in_rdy, out_z, out_side, out_avail
  );

  modport slave (
    input  in_a, in_b, in_side, in_vld,
    output in_rdy, out_z, out_side, out_avail
  );
endinterface

// File: rtl/mod_mult_serial_pp.sv
// Combinational MOD_W x CHUNK_W partial product of a and the selected b slice.
// Kept separate so a DSP-mapped implementation can be dropped in.
module mod_mult_serial_pp
  import mod_mult_serial_pkg::*;
#(
  parameter int MOD_W   = 64,
  parameter int CHUNK_W = 16
) (
  input  logic [MOD_W-1:0]                         i_a,
  input  logic [MOD_W-1:0]                         i_b,
  input  logic [cnt_w(MOD_W, CHUNK_W)-1:0]         i_sel,
  output logic [MOD_W+CHUNK_W-1:0]                 o_pp
);
  localparam int NB   = nb_chunk(MOD_W, CHUNK_W);
  localparam int PP_W = MOD_W + CHUNK_W;

  logic [CHUNK_W-1:0] w_slice [NB];
  logic [CHUNK_W-1:0] w_sel_slice;

  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_slice
      assign w_slice[gi] = i_b[gi*CHUNK_W +: CHUNK_W];
    end
  endgenerate

  assign w_sel_slice = w_slice[i_sel];
  assign o_pp        = PP_W'(i_a) * PP_W'(w_sel_slice);
endmodule

// File: rtl/mod_mult_serial_prod.sv
// Serial shift-accumulate multiplier: one CHUNK_W slice of b per cycle, full 2*MOD_W product.
// Define MOD_MULT_SERIAL_EARLY_EXIT_EN to stop after the highest non-zero slice of b.
module mod_mult_serial_prod
  import mod_mult_serial_pkg::*;
#(
  parameter int MOD_W    = 64,
  parameter int CHUNK_W  = 16,
  parameter int SIDE_W   = 0,
  parameter int RST_SIDE = 0
) (
  input  logic                  clk,
  input  logic                  a_rst,
  mod_mult_serial_prod_if.slave bus
);
  localparam int NB_CHUNK = nb_chunk(MOD_W, CHUNK_W);
  localparam int CNT_W    = cnt_w(MOD_W, CHUNK_W);
  localparam int SW       = (SIDE_W > 0) ? SIDE_W : 1;
  localparam int P_W      = 2 * MOD_W;
  localparam int PP_W     = MOD_W + CHUNK_W;

  generate
    if ((MOD_W % CHUNK_W) != 0) begin : g_bad_cfg
      $fatal(1, "mod_mult_serial_prod: MOD_W must be a multiple of CHUNK_W");
    end
  endgenerate

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [MOD_W-1:0]   r_a;
  logic [MOD_W-1:0]   r_b;
  logic [SW-1:0]      r_side;
  logic [P_W-1:0]     r_acc;
  logic [P_W-1:0]     r_z;
  logic               r_avail;
  logic [SW-1:0]      r_out_side;

  logic [CNT_W-1:0]   w_last;
  logic [CNT_W-1:0]   w_last_new;
  logic [PP_W-1:0]    w_pp;
  logic [P_W-1:0]     w_pp_sh;
  logic [P_W-1:0]     w_sum;
  logic               w_done;

`ifdef MOD_MULT_SERIAL_EARLY_EXIT_EN
  logic [CNT_W-1:0]   r_last;
  logic [MAX_W-1:0]   w_b_ext;
  int                 w_hnz;

  assign w_b_ext    = MAX_W'(bus.in_b);
  assign w_hnz      = highest_nz_chunk(w_b_ext, MOD_W, CHUNK_W);
  assign w_last_new = w_hnz[CNT_W-1:0];
  assign w_last     = r_last;

  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      r_last <= '0;
    end else if ((r_state == IDLE) && bus.in_vld) begin
      r_last <= w_last_new;
    end
  end
`else
  assign w_last_new = CNT_W'(NB_CHUNK - 1);
  assign w_last     = w_last_new;
`endif

  mod_mult_serial_pp #(
    .MOD_W   (MOD_W),
    .CHUNK_W (CHUNK_W)
  ) u_pp (
    .i_a   (r_a),
    .i_b   (r_b),
    .i_sel (r_cnt),
    .o_pp  (w_pp)
  );

  assign w_pp_sh = P_W'(w_pp) << (int'(r_cnt) * CHUNK_W);
  assign w_sum   = r_acc + w_pp_sh;
  assign w_done  = (r_state == RUN) && (r_cnt == w_last);

  // Ready is gated by reset directly so it reads 0 for the whole reset pulse.
  assign bus.in_rdy    = (r_state == IDLE) && !a_rst;
  assign bus.out_z     = r_z;
  assign bus.out_avail = r_avail;
  assign bus.out_side  = r_out_side;

  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_side  <= '0;
      r_acc   <= '0;
      r_z     <= '0;
      r_avail <= 1'b0;
    end else begin
      r_avail <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.in_vld) begin
            r_a     <= bus.in_a;
            r_b     <= bus.in_b;
            r_side  <= bus.in_side;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_state <= RUN;
          end
        end
        RUN: begin
          if (r_cnt == w_last) begin
            r_z     <= w_sum;
            r_avail <= 1'b1;
            r_cnt   <= '0;
            r_state <= IDLE;
          end else begin
            r_acc <= w_sum;
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Result side data: reset to zero, to all ones, or left unreset.
  generate
    if (RST_SIDE[0]) begin : g_side_rst0
      always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst)       r_out_side <= '0;
        else if (w_done) r_out_side <= r_side;
      end
    end else if (RST_SIDE[1]) begin : g_side_rst1
      always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst)       r_out_side <= '1;
        else if (w_done) r_out_side <= r_side;
      end
    end else begin : g_side_norst
      always_ff @(posedge clk) begin
        if (w_done) r_out_side <= r_side;
      end
    end
  endgenerate
endmodule

// File: tb/tb_mod_mult_serial_prod.sv
// Directed self-checking bench for mod_mult_serial_prod (MOD_W=64, CHUNK_W=16, SIDE_W=8, RST_SIDE=2).
// Latency expectations follow MOD_MULT_SERIAL_EARLY_EXIT_EN when it is defined.
module tb_mod_mult_serial_prod;
`ifdef MOD_MULT_SERIAL_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif

  logic clk;
  logic a_rst;
  int   total;
  int   bad;

  mod_mult_serial_prod_if #(.MOD_W(64), .SIDE_W(8)) bus ();

  mod_mult_serial_prod #(
    .MOD_W    (64),
    .CHUNK_W  (16),
    .SIDE_W   (8),
    .RST_SIDE (2)
  ) dut (
    .clk   (clk),
    .a_rst (a_rst),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Transfer one operation, then wait (bounded) for the result pulse.
  // lat = edges after the transfer edge until out_avail is seen, -1 on timeout.
  task automatic do_op(input logic [63:0] a, input logic [63:0] b,
                       input logic [7:0] side, output int lat);
    int w;
    w = 0;
    while (!bus.in_rdy && w < 20) begin
      @(posedge clk);
      #1;
      w++;
    end
    bus.in_a    = a;
    bus.in_b    = b;
    bus.in_side = side;
    bus.in_vld  = 1'b1;
    @(posedge clk);
    #1;
    bus.in_vld = 1'b0;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (bus.out_avail) begin
        lat = k;
        break;
      end
    end
    $display("op a=%0h b=%0h side=%0h -> z=%0h side=%0h lat=%0d",
             a, b, side, bus.out_z, bus.out_side, lat);
  endtask

  initial begin
    int lat;
    int npulse;
    int p1;
    int p2;
    logic [127:0] z1;
    logic [127:0] z2;

    total       = 0;
    bad         = 0;
    a_rst       = 1'b1;
    bus.in_a    = '0;
    bus.in_b    = '0;
    bus.in_side = '0;
    bus.in_vld  = 1'b0;

    // Reset state
    #2;
    chk("rst_rdy", bus.in_rdy, 1'b0);
    chk("rst_avail", bus.out_avail, 1'b0);
    chk("rst_z", bus.out_z, 128'd0);
    chk("rst_side", bus.out_side, 8'hFF);
    repeat (2) @(posedge clk);
    @(negedge clk);
    a_rst = 1'b0;
    #1;
    chk("rel_rdy", bus.in_rdy, 1'b1);

    // Small operands
    do_op(64'd3, 64'd5, 8'h11, lat);
    chk("small_lat", lat, EE ? 1 : 4);
    chk("small_z", bus.out_z, 128'd15);
    chk("small_rdy", bus.in_rdy, 1'b1);
    @(posedge clk);
    #1;
    chk("small_pulse_end", bus.out_avail, 1'b0);
    chk("small_z_hold", bus.out_z, 128'd15);

    // Max operands
    do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 8'h22, lat);
    chk("max_lat", lat, 4);
    chk("max_z", bus.out_z, 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001);

    // Back-to-back with in_vld held high
    bus.in_a   = 64'h1234;
    bus.in_b   = 64'h1_0000;
    bus.in_vld = 1'b1;
    @(posedge clk);
    #1;
    bus.in_a = 64'h8000_0000_0000_0000;
    bus.in_b = 64'd2;
    npulse = 0;
    p1 = -1;
    p2 = -1;
    z1 = '0;
    z2 = '0;
    for (int i = 1; i <= 14; i++) begin
      @(posedge clk);
      #1;
      if (i == (EE ? 3 : 5)) begin
        chk("b2b_rdy_run", bus.in_rdy, 1'b0);
        bus.in_vld = 1'b0;
      end
      if (bus.out_avail) begin
        npulse++;
        if (npulse == 1) begin
          p1 = i;
          z1 = bus.out_z;
        end else begin
          p2 = i;
          z2 = bus.out_z;
        end
      end
    end
    $display("b2b pulses=%0d p1=%0d z1=%0h p2=%0d z2=%0h", npulse, p1, z1, p2, z2);
    chk("b2b_npulse", npulse, 2);
    chk("b2b_p1", p1, EE ? 2 : 4);
    chk("b2b_z1", z1, 128'h1234_0000);
    chk("b2b_p2", p2, EE ? 4 : 9);
    chk("b2b_z2", z2, 128'h1_0000_0000_0000_0000);

    // Reset mid-operation
    bus.in_a    = 64'd11;
    bus.in_b    = 64'h0003_0000_0000_0000;
    bus.in_vld  = 1'b1;
    @(posedge clk);
    #1;
    bus.in_vld = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    a_rst = 1'b1;
    #1;
    chk("midrst_rdy", bus.in_rdy, 1'b0);
    chk("midrst_z", bus.out_z, 128'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    a_rst = 1'b0;
    #1;
    chk("midrst_rel_rdy", bus.in_rdy, 1'b1);
    npulse = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_avail) npulse++;
    end
    $display("after mid-op reset: pulses=%0d z=%0h", npulse, bus.out_z);
    chk("midrst_no_pulse", npulse, 0);
    chk("midrst_z_after", bus.out_z, 128'd0);
    chk("midrst_side", bus.out_side, 8'hFF);
    do_op(64'd7, 64'd9, 8'hA5, lat);
    chk("post_rst_lat", lat, EE ? 1 : 4);
    chk("post_rst_z", bus.out_z, 128'd63);
    chk("side_a5", bus.out_side, 8'hA5);

    // Early-exit candidates (full latency when the feature is off)
    do_op(64'h1111, 64'd7, 8'h01, lat);
    chk("ee_b7_lat", lat, EE ? 1 : 4);
    chk("ee_b7_z", bus.out_z, 128'h7777);
    do_op(64'd5, 64'h1_0000_0000, 8'h02, lat);
    chk("ee_b32_lat", lat, EE ? 3 : 4);
    chk("ee_b32_z", bus.out_z, 128'h5_0000_0000);
    chk("ee_b32_side", bus.out_side, 8'h02);
    do_op(64'hDEAD, 64'd0, 8'h03, lat);
    chk("ee_b0_lat", lat, EE ? 1 : 4);
    chk("ee_b0_z", bus.out_z, 128'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mod_mult_serial_prod.md
Name: mod_mult_serial_prod

Overview:
- Sequential, area-lean integer multiplier that produces the full 2*MOD_W-bit product of two MOD_W-bit residues.
- Sits directly upstream of the Solinas-2 half-width modular reduction stage and drives its a/in_avail/in_side inputs.
- Multiplies operand a by one CHUNK_W-bit slice of operand b per cycle and shift-accumulates, trading throughput for a single narrow MOD_W x CHUNK_W multiplier.

Parameters:
- MOD_W, 64, operand width; the product is 2*MOD_W bits.
- CHUNK_W, 16, b-slice width per cycle; MOD_W % CHUNK_W must be 0, else $fatal.
- SIDE_W, 0, side-data width carried alongside the operation; 0 means unused.
- RST_SIDE, 0, [0]=1: out_side resets to 0; [1]=1: out_side resets to all ones; 0: out_side is not reset.

Ports:
- clk, in, 1, clock.
- a_rst, in, 1, asynchronous active-high reset.
- in_a, in, MOD_W, multiplicand.
- in_b, in, MOD_W, multiplier.
- in_side, in, SIDE_W, side data latched at acceptance.
- in_vld, in, 1, operand valid.
- in_rdy, out, 1, block can accept; a transfer occurs when in_vld & in_rdy at a rising edge.
- out_z, out, 2*MOD_W, product in_a*in_b; held stable until the next result.
- out_side, out, SIDE_W, side data of the result.
- out_avail, out, 1, single-cycle pulse marking a new out_z.

Behaviour:
- Clocking and reset: one clock, clk. Reset a_rst is asynchronous and active-high.
- NB_CHUNK = MOD_W/CHUNK_W.
- FSM states:
  - IDLE: in_rdy=1.
  - RUN: in_rdy=0; counter cnt runs 0..NB_CHUNK-1.
- Transitions:
  - IDLE->RUN on transfer: latch a, b, side; acc=0; cnt=0.
  - RUN, cnt<last: acc += (a*b[cnt*CHUNK_W+:CHUNK_W]) << (cnt*CHUNK_W); cnt++.
  - RUN, cnt==last: out_z <= acc + current partial product; out_side <= latched side; out_avail <= 1; state->IDLE.
- Latency: transfer at edge T gives out_avail=1 in the cycle after edge T+NB_CHUNK, for exactly one cycle.
  - in_rdy rises the same cycle, so the next transfer is at edge T+NB_CHUNK+1.
  - Throughput is one operation per NB_CHUNK+1 cycles.
- in_vld while in RUN is ignored: no capture, no error. The upstream holds its data until in_rdy.
- Arithmetic:
  - acc is 2*MOD_W bits and unsigned.
  - Each partial product is MOD_W+CHUNK_W bits, zero-extended before the shift.
  - No overflow is possible because the max product is (2^MOD_W-1)^2 < 2^(2*MOD_W).
- No modular reduction is done here; out_z is the raw product. Operands need not be < MOD_M.
- out_avail is a pulse; there is no backpressure from downstream (the reduction stage always accepts).
- Reset values:
  - state=IDLE, cnt=0, acc=0, out_z=0, out_avail=0.
  - out_side follows RST_SIDE.
  - in_rdy=0 while a_rst is asserted, and 1 from the first cycle after deassertion.
- Reset mid-RUN: the operation is dropped and no out_avail is produced. After release the block is idle and ready.
- in_b=0 or in_a=0: runs the normal sequence and outputs 0 with normal latency. Early exit applies only if the optional feature is enabled.

Optional Feature:
- Macro: MOD_MULT_SERIAL_EARLY_EXIT_EN.
- Defined:
  - At acceptance, compute last = index of the highest non-zero CHUNK_W slice of in_b (0 if in_b==0).
  - RUN ends at cnt==last, so latency is last+1 cycles.
  - out_z is identical to the full computation.
- Undefined: last is fixed at NB_CHUNK-1 and latency is always NB_CHUNK.

Decomposition:
- Package mod_mult_serial_pkg holds:
  - the state enum (IDLE, RUN);
  - NB_CHUNK and CNT_W=$clog2(NB_CHUNK) as functions/params of MOD_W, CHUNK_W;
  - the function highest_nz_chunk() used by the early-exit logic.
- Sub-module mod_mult_serial_pp: combinational MOD_W x CHUNK_W multiplier with slice select. It is isolated so a DSP-mapped variant can replace it.

Test Plan (MOD_W=64, CHUNK_W=16, NB_CHUNK=4):
- Small operands: a=3, b=5 transferred at edge T -> out_z=15, out_avail pulse after edge T+4, in_rdy=1 from then.
- Max operands: a=b=0xFFFF_FFFF_FFFF_FFFF -> out_z=0xFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001.
- Back-to-back with in_vld held high: pairs (0x1234,0x10000) then (2^63,2) -> results 0x1234_0000 then 2^64, transfers at edges T and T+5, pulses 5 cycles apart; in_vld during RUN causes no capture.
- Reset mid-operation: a_rst pulsed 2 cycles after transfer -> no out_avail, out_z=0, in_rdy=0 during reset then 1; next op a=7,b=9 -> 63.
- Side data with SIDE_W=8, RST_SIDE=2: out_side=0xFF after reset; in_side=0xA5 with an op -> out_side=0xA5 coincident with out_avail.
- Early exit with MOD_MULT_SERIAL_EARLY_EXIT_EN defined:
  - b=7 -> latency 1.
  - b=0x1_0000_0000 -> latency 3.
  - b=0 -> out_z=0, latency 1.
  - With the macro undefined, all three have latency 4.
